// File: rtl/bp_me_io_cmd_arbiter.sv
// Purpose: merges two loader command streams round-robin onto one host link and routes responses back by tag.
// Latency: zero cycles on both the command and response paths; only the tag FIFO and grant state are registered.
// Backpressure: mem_cmd_ready_i and a full tag FIFO stall the winner; the head source's resp_ready gates mem_resp_yumi_o.
module bp_me_io_cmd_arbiter #(
  parameter int msg_width_p  = 128,
  parameter int els_p        = 4,
  parameter int cnt_width_lp = $clog2(els_p+1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [msg_width_p-1:0]  src0_cmd_i,
  input  logic                    src0_cmd_v_i,
  output logic                    src0_cmd_ready_o,
  input  logic [msg_width_p-1:0]  src1_cmd_i,
  input  logic                    src1_cmd_v_i,
  output logic                    src1_cmd_ready_o,

  output logic [msg_width_p-1:0]  src0_resp_o,
  output logic                    src0_resp_v_o,
  input  logic                    src0_resp_ready_i,
  output logic [msg_width_p-1:0]  src1_resp_o,
  output logic                    src1_resp_v_o,
  input  logic                    src1_resp_ready_i,

  output logic [msg_width_p-1:0]  mem_cmd_o,
  output logic                    mem_cmd_v_o,
  input  logic                    mem_cmd_ready_i,

  input  logic [msg_width_p-1:0]  mem_resp_i,
  input  logic                    mem_resp_v_i,
  output logic                    mem_resp_yumi_o,

  output logic [cnt_width_lp-1:0] outstanding_o,
  output logic                    err_o
);

  localparam int ptr_width_lp = $clog2(els_p);

  // Tag FIFO holds the source id (0/1) of every issued, unanswered command.
  logic [els_p-1:0]        tag_q, tag_d;
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  // last_q: source granted on the most recent handshake.
  // hold_q/held_q: a stall was in progress last cycle, and which source owned it.
  logic                    last_q, last_d;
  logic                    hold_q, hold_d;
  logic                    held_q, held_d;
  logic                    err_q, err_d;

  logic full, empty, win, head, head_rdy, cmd_rdy, resp_ok, push, pop;

  assign full  = (cnt_q == cnt_width_lp'(els_p));
  assign empty = (cnt_q == '0);
  assign head  = tag_q[rd_ptr_q];

  // Pick the winner: a stalled grant is kept while its source stays valid, otherwise round-robin.
  always_comb begin
    win = 1'b0;
    if (hold_q && (held_q ? src1_cmd_v_i : src0_cmd_v_i)) begin
      win = held_q;
    end else if (src0_cmd_v_i && src1_cmd_v_i) begin
      win = ~last_q;
    end else begin
      win = src1_cmd_v_i;
    end
  end

  // Command path; every handshake output is forced low while reset is asserted.
  assign cmd_rdy          = reset_i & mem_cmd_ready_i & ~full;
  assign mem_cmd_v_o      = reset_i & (src0_cmd_v_i | src1_cmd_v_i) & ~full;
  assign mem_cmd_o        = win ? src1_cmd_i : src0_cmd_i;
  assign src0_cmd_ready_o = cmd_rdy & ~win;
  assign src1_cmd_ready_o = cmd_rdy & win;
  assign push             = mem_cmd_v_o & mem_cmd_ready_i;

  // Response path: only the source at the FIFO head sees a valid response.
  assign resp_ok          = reset_i & mem_resp_v_i & ~empty;
  assign head_rdy         = head ? src1_resp_ready_i : src0_resp_ready_i;
  assign src0_resp_o      = mem_resp_i;
  assign src1_resp_o      = mem_resp_i;
  assign src0_resp_v_o    = resp_ok & ~head;
  assign src1_resp_v_o    = resp_ok & head;
  assign mem_resp_yumi_o  = resp_ok & head_rdy;
  assign pop              = mem_resp_yumi_o;

  assign outstanding_o    = cnt_q;
  assign err_o            = err_q;

  // Next-state for the tag FIFO, counter, grant history and orphan flag.
  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    hold_d   = mem_cmd_v_o & ~mem_cmd_ready_i;
    held_d   = win;
    err_d    = err_q | (mem_resp_v_i & empty);
    if (push) begin
      tag_d[wr_ptr_q] = win;
      wr_ptr_d = (wr_ptr_q == ptr_width_lp'(els_p-1)) ? '0 : wr_ptr_q + ptr_width_lp'(1);
      last_d   = win;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == ptr_width_lp'(els_p-1)) ? '0 : rd_ptr_q + ptr_width_lp'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_width_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_width_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset drops all tags and makes src0 win the first tie.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      hold_q   <= 1'b0;
      held_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      held_q   <= held_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Bench for bp_me_io_cmd_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_bp_me_io_cmd_arbiter;

  localparam int MW  = 128;
  localparam int ELS = 4;
  localparam int CW  = $clog2(ELS+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [MW-1:0] c0, c1, rd;
  logic          v0, v1, cr, rv, r0, r1;

  logic [MW-1:0] src0_resp_o, src1_resp_o, mem_cmd_o;
  logic          src0_cmd_ready_o, src1_cmd_ready_o;
  logic          src0_resp_v_o, src1_resp_v_o, mem_cmd_v_o, mem_resp_yumi_o, err_o;
  logic [CW-1:0] outstanding_o;

  int chk  = 0;
  int pass = 0;

  // Reference model: a queue of source ids plus grant history.
  int  q[$];
  bit  m_err;
  bit  m_last;
  int  m_hold;

  bit            e_win, e_cmd_v, e_rdy0, e_rdy1, e_rv0, e_rv1, e_yumi;
  logic [5:0]    e_ctl;
  logic [MW-1:0] e_cmd;

  bp_me_io_cmd_arbiter #(.msg_width_p(MW), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .src0_cmd_i(c0), .src0_cmd_v_i(v0), .src0_cmd_ready_o(src0_cmd_ready_o),
    .src1_cmd_i(c1), .src1_cmd_v_i(v1), .src1_cmd_ready_o(src1_cmd_ready_o),
    .src0_resp_o(src0_resp_o), .src0_resp_v_o(src0_resp_v_o), .src0_resp_ready_i(r0),
    .src1_resp_o(src1_resp_o), .src1_resp_v_o(src1_resp_v_o), .src1_resp_ready_i(r1),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(cr),
    .mem_resp_i(rd), .mem_resp_v_i(rv), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] ctl_got();
    return {mem_cmd_v_o, src0_cmd_ready_o, src1_cmd_ready_o, src0_resp_v_o, src1_resp_v_o, mem_resp_yumi_o};
  endfunction

  function automatic logic [MW-1:0] rnd_msg();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    q.delete();
    m_err  = 1'b0;
    m_last = 1'b1;
    m_hold = -1;
  endtask

  // Expected combinational outputs from the current model state and inputs.
  task automatic eval();
    bit full, empty, rok;
    int h;
    full  = (q.size() == ELS);
    empty = (q.size() == 0);
    h     = empty ? 0 : q[0];
    if (m_hold >= 0 && ((m_hold == 1) ? v1 : v0)) e_win = (m_hold == 1);
    else if (v0 && v1)                             e_win = !m_last;
    else                                           e_win = v1;
    e_cmd   = e_win ? c1 : c0;
    e_cmd_v = rst_n && (v0 || v1) && !full;
    e_rdy0  = rst_n && cr && !full && !e_win;
    e_rdy1  = rst_n && cr && !full && e_win;
    rok     = rst_n && rv && !empty;
    e_rv0   = rok && (h == 0);
    e_rv1   = rok && (h == 1);
    e_yumi  = rok && ((h == 1) ? r1 : r0);
    e_ctl   = {e_cmd_v, e_rdy0, e_rdy1, e_rv0, e_rv1, e_yumi};
  endtask

  // Advance one clock edge, updating the model from its own view of push/pop.
  task automatic tick();
    bit push, pop, w, stall, orphan;
    eval();
    push   = e_cmd_v && cr;
    pop    = e_yumi;
    w      = e_win;
    stall  = e_cmd_v && !cr;
    orphan = rst_n && rv && (q.size() == 0);
    @(posedge clk);
    if (rst_n) begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(int'(w));
        m_last = w;
      end
      m_hold = stall ? int'(w) : -1;
      if (orphan) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; cr = 0; rv = 0; r0 = 0; r1 = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    c0 = rnd_msg(); c1 = rnd_msg(); rd = rnd_msg();
    v0 = 1; v1 = 1; cr = 1; rv = 1; r0 = 1; r1 = 1;
    #2;
    chk++; if (ctl_got() !== 6'b000000) $display("FAIL reset_ctl got %b want 000000", ctl_got()); else pass++;
    chk++; if (outstanding_o !== '0) $display("FAIL reset_outstanding got %0d want 0", outstanding_o); else pass++;
    chk++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else pass++;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    v0 = 1; v1 = 1; cr = 1;
    for (int k = 0; k < 4; k++) begin
      c0 = rnd_msg(); c1 = rnd_msg();
      #1;
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      chk++; if ({src0_cmd_ready_o, src1_cmd_ready_o} !== exp_g)
        $display("FAIL tie_grant%0d got %b want %b", k, {src0_cmd_ready_o, src1_cmd_ready_o}, exp_g); else pass++;
      chk++; if (mem_cmd_o !== ((k % 2 == 0) ? c0 : c1))
        $display("FAIL tie_data%0d got %h want %h", k, mem_cmd_o, (k % 2 == 0) ? c0 : c1); else pass++;
      tick();
      chk++; if (outstanding_o !== CW'(k+1)) $display("FAIL tie_outstanding%0d got %0d want %0d", k, outstanding_o, k+1); else pass++;
    end
    #1;
    chk++; if ({mem_cmd_v_o, src0_cmd_ready_o, src1_cmd_ready_o} !== 3'b000)
      $display("FAIL tie_full_ready got %b want 000", {mem_cmd_v_o, src0_cmd_ready_o, src1_cmd_ready_o}); else pass++;
  endtask

  task automatic test_full_pop();
    v1 = 0; v0 = 1; c0 = rnd_msg(); cr = 1;
    rv = 1; rd = rnd_msg(); r0 = 1; r1 = 0;
    #1;
    chk++; if (ctl_got() !== 6'b000101) $display("FAIL fullpop_ctl got %b want 000101", ctl_got()); else pass++;
    tick();
    chk++; if (outstanding_o !== CW'(3)) $display("FAIL fullpop_pop got %0d want 3", outstanding_o); else pass++;
    rv = 0;
    #1;
    chk++; if (ctl_got() !== 6'b110000) $display("FAIL fullpop_accept_ctl got %b want 110000", ctl_got()); else pass++;
    tick();
    chk++; if (outstanding_o !== CW'(4)) $display("FAIL fullpop_push got %0d want 4", outstanding_o); else pass++;
    v0 = 0; rv = 1; r0 = 1; r1 = 1;
    repeat (4) tick();
    chk++; if (outstanding_o !== '0) $display("FAIL fullpop_drain got %0d want 0", outstanding_o); else pass++;
    idle();
  endtask

  task automatic test_routing();
    logic [MW-1:0] vals [3];
    int            hd [3];
    vals[0] = MW'(32'hA); vals[1] = MW'(32'hB); vals[2] = MW'(32'hC);
    hd[0] = 1; hd[1] = 0; hd[2] = 1;
    cr = 1;
    for (int k = 0; k < 3; k++) begin
      v0 = (hd[k] == 0); v1 = (hd[k] == 1);
      c0 = rnd_msg(); c1 = rnd_msg();
      tick();
    end
    idle();
    chk++; if (outstanding_o !== CW'(3)) $display("FAIL route_count got %0d want 3", outstanding_o); else pass++;
    rv = 1; r0 = 1; r1 = 1;
    for (int k = 0; k < 3; k++) begin
      rd = vals[k];
      #1;
      chk++; if ({src0_resp_v_o, src1_resp_v_o} !== ((hd[k] == 1) ? 2'b01 : 2'b10))
        $display("FAIL route_v%0d got %b want %b", k, {src0_resp_v_o, src1_resp_v_o}, (hd[k] == 1) ? 2'b01 : 2'b10); else pass++;
      chk++; if (((hd[k] == 1) ? src1_resp_o : src0_resp_o) !== vals[k])
        $display("FAIL route_data%0d got %h want %h", k, (hd[k] == 1) ? src1_resp_o : src0_resp_o, vals[k]); else pass++;
      tick();
    end
    idle();
    chk++; if (outstanding_o !== '0) $display("FAIL route_drain got %0d want 0", outstanding_o); else pass++;
  endtask

  task automatic test_backpressure();
    v0 = 1; c0 = rnd_msg(); cr = 1;
    tick();
    idle();
    rv = 1; rd = rnd_msg(); r0 = 0; r1 = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk++; if (ctl_got() !== 6'b000100) $display("FAIL bp_ctl%0d got %b want 000100", k, ctl_got()); else pass++;
      tick();
      chk++; if (outstanding_o !== CW'(1)) $display("FAIL bp_count%0d got %0d want 1", k, outstanding_o); else pass++;
    end
    r0 = 1;
    #1;
    chk++; if (mem_resp_yumi_o !== 1'b1) $display("FAIL bp_release got %b want 1", mem_resp_yumi_o); else pass++;
    tick();
    idle();
  endtask

  task automatic test_stall_hold();
    logic [MW-1:0] s1;
    v1 = 1; c1 = rnd_msg(); cr = 1;
    tick();
    s1 = rnd_msg(); c1 = s1; cr = 0;
    #1;
    chk++; if (ctl_got() !== 6'b100000 || mem_cmd_o !== s1)
      $display("FAIL stall_start got ctl %b data %h want 100000 %h", ctl_got(), mem_cmd_o, s1); else pass++;
    tick();
    v0 = 1; c0 = rnd_msg();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk++; if (mem_cmd_o !== s1) $display("FAIL stall_hold%0d got %h want %h", k, mem_cmd_o, s1); else pass++;
      tick();
    end
    cr = 1;
    #1;
    chk++; if ({src0_cmd_ready_o, src1_cmd_ready_o} !== 2'b01 || mem_cmd_o !== s1)
      $display("FAIL stall_accept got rdy %b data %h want 01 %h", {src0_cmd_ready_o, src1_cmd_ready_o}, mem_cmd_o, s1); else pass++;
    tick();
    v1 = 0;
    #1;
    chk++; if ({src0_cmd_ready_o, src1_cmd_ready_o} !== 2'b10) $display("FAIL stall_next got %b want 10", {src0_cmd_ready_o, src1_cmd_ready_o}); else pass++;
    tick();
    idle();
    chk++; if (outstanding_o !== CW'(3)) $display("FAIL stall_count got %0d want 3", outstanding_o); else pass++;
    rv = 1; r0 = 1; r1 = 1;
    repeat (3) tick();
    idle();
  endtask

  task automatic test_orphan();
    rv = 1; rd = rnd_msg(); r0 = 1; r1 = 1;
    #1;
    chk++; if (ctl_got() !== 6'b000000) $display("FAIL orphan_ctl got %b want 000000", ctl_got()); else pass++;
    chk++; if (err_o !== 1'b0) $display("FAIL orphan_pre got %b want 0", err_o); else pass++;
    tick();
    rv = 0;
    chk++; if (err_o !== 1'b1) $display("FAIL orphan_set got %b want 1", err_o); else pass++;
    repeat (3) tick();
    chk++; if (err_o !== 1'b1) $display("FAIL orphan_sticky got %b want 1", err_o); else pass++;
    idle();
  endtask

  task automatic test_mid_reset();
    v0 = 1; v1 = 1; cr = 1;
    repeat (2) tick();
    idle();
    chk++; if (outstanding_o !== CW'(2)) $display("FAIL midrst_pre got %0d want 2", outstanding_o); else pass++;
    #3;
    rst_n = 0;
    model_reset();
    #1;
    chk++; if (outstanding_o !== '0 || err_o !== 1'b0)
      $display("FAIL midrst_clear got cnt %0d err %b want 0 0", outstanding_o, err_o); else pass++;
    @(posedge clk);
    #1;
    rst_n = 1;
    v0 = 1; v1 = 1; cr = 1; c0 = rnd_msg(); c1 = rnd_msg();
    #1;
    chk++; if ({src0_cmd_ready_o, src1_cmd_ready_o} !== 2'b10 || mem_cmd_o !== c0)
      $display("FAIL midrst_tie got rdy %b data %h want 10 %h", {src0_cmd_ready_o, src1_cmd_ready_o}, mem_cmd_o, c0); else pass++;
    tick();
    idle();
    rv = 1; r0 = 1;
    tick();
    idle();
  endtask

  task automatic test_random();
    bit acc, acc_w;
    for (int n = 0; n < 800; n++) begin
      if (!v0 && ($urandom_range(2) == 0)) begin v0 = 1; c0 = rnd_msg(); end
      if (!v1 && ($urandom_range(2) == 0)) begin v1 = 1; c1 = rnd_msg(); end
      cr = ($urandom_range(3) != 0);
      rv = ($urandom_range(2) == 0);
      rd = rnd_msg();
      r0 = ($urandom_range(3) != 0);
      r1 = ($urandom_range(3) != 0);
      #1;
      eval();
      chk++; if (ctl_got() !== e_ctl) $display("FAIL rand_ctl cyc%0d got %b want %b", n, ctl_got(), e_ctl); else pass++;
      if (e_cmd_v) begin
        chk++; if (mem_cmd_o !== e_cmd) $display("FAIL rand_cmd cyc%0d got %h want %h", n, mem_cmd_o, e_cmd); else pass++;
      end
      if (e_rv0 || e_rv1) begin
        chk++; if ((e_rv1 ? src1_resp_o : src0_resp_o) !== rd)
          $display("FAIL rand_resp cyc%0d got %h want %h", n, e_rv1 ? src1_resp_o : src0_resp_o, rd); else pass++;
      end
      acc   = e_cmd_v && cr;
      acc_w = e_win;
      tick();
      if (acc) begin
        if (acc_w) v1 = 0; else v0 = 0;
      end
      chk++; if (outstanding_o !== CW'(q.size())) $display("FAIL rand_count cyc%0d got %0d want %0d", n, outstanding_o, q.size()); else pass++;
      chk++; if (err_o !== m_err) $display("FAIL rand_err cyc%0d got %b want %b", n, err_o, m_err); else pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    c0 = '0; c1 = '0; rd = '0;
    test_reset();
    test_tie();
    test_full_pop();
    test_routing();
    test_backpressure();
    test_stall_hold();
    test_orphan();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
